// File: rtl/iob_skid_buf_pkg.sv
// Shared constants for the two-entry skid buffer: occupancy width and state encoding.
// The state value doubles as the occupancy count reported on the level port.
package iob_skid_buf_pkg;

  localparam int LEVEL_W = 2;
  localparam int ST_W    = LEVEL_W + 2;

  typedef enum logic [LEVEL_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/iob_skid_buf_if.sv
// Valid/ready word stream; master drives valid+data, slave drives ready.
interface iob_skid_buf_if #(
  parameter int DATA_W = 32
);

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/iob_skid_reg.sv
// W-bit register with enable, synchronous clear and asynchronous active-low clear to zero.
// Synchronous clear takes priority over the enable.
module iob_skid_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/iob_skid_buf.sv
// Two-entry elastic stage: latency 1, full throughput; s_ready, m_valid, level are flop outputs,
// so backpressure from m_ready reaches s_ready only through a register (no comb ready path).
module iob_skid_buf
  import iob_skid_buf_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               rst,
  iob_skid_buf_if.slave      s_if,
  iob_skid_buf_if.master     m_if,
  output logic [LEVEL_W-1:0] level
);

  logic               in_xfer;
  logic               out_xfer;
  logic [LEVEL_W-1:0] lvl_q, lvl_d;
  logic               vld_q, full_q;
  logic [ST_W-1:0]    st_q, st_d;
  logic               main_en, skid_en;
  logic [DATA_W-1:0]  main_d, main_q, skid_q;

  assign in_xfer  = s_if.valid & ~full_q;
  assign out_xfer = vld_q & m_if.ready;

  // Valid and full flags are stored decoded next to the level so the handshake outputs are pure flops.
  assign st_d = {(lvl_d == FULL), (lvl_d != EMPTY), lvl_d};
  assign {full_q, vld_q, lvl_q} = st_q;

  iob_skid_reg #(.W(ST_W)) u_state (
    .clk    (clk),
    .arst_n (arst_n),
    .clr_i  (rst),
    .en_i   (1'b1),
    .d_i    (st_d),
    .q_o    (st_q)
  );

  always_comb begin
    lvl_d   = lvl_q;
    main_en = 1'b0;
    main_d  = s_if.data;
    skid_en = 1'b0;
    unique case (lvl_q)
      EMPTY: begin
        if (in_xfer) begin
          lvl_d   = ONE;
          main_en = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (out_xfer) begin
          lvl_d = EMPTY;
        end else if (in_xfer) begin
          lvl_d   = FULL;
          skid_en = 1'b1;
        end
      end
      FULL: begin
        if (out_xfer) begin
          lvl_d   = ONE;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
      default: lvl_d = EMPTY;
    endcase
  end

  // A flush leaves m_data untouched, so the main word register never sees rst as a clear.
  iob_skid_reg #(.W(DATA_W)) u_main (
    .clk    (clk),
    .arst_n (arst_n),
    .clr_i  (1'b0),
    .en_i   (main_en & ~rst),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  iob_skid_reg #(.W(DATA_W)) u_skid (
    .clk    (clk),
    .arst_n (arst_n),
    .clr_i  (rst),
    .en_i   (skid_en),
    .d_i    (s_if.data),
    .q_o    (skid_q)
  );

  always_comb begin
    m_if.valid = vld_q;
    m_if.data  = main_q;
    s_if.ready = ~full_q;
    level      = lvl_q;
  end

endmodule

// File: tb/tb_iob_skid_buf.sv
// Directed bench for iob_skid_buf: stimulus pushes hand-picked expected words into a queue,
// a negedge monitor pops and compares on every output transfer; directed checks cover level/timing.
module tb_iob_skid_buf;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  level;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  iob_skid_buf_if #(.DATA_W(32)) s_if ();
  iob_skid_buf_if #(.DATA_W(32)) m_if ();

  iob_skid_buf #(.DATA_W(32)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .rst    (rst),
    .s_if   (s_if),
    .m_if   (m_if),
    .level  (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs change only at posedge+1, so values seen at negedge are the ones the next edge uses.
  always @(negedge clk) begin
    if (arst_n && !rst && m_if.valid && m_if.ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got %h expected no word at %0t", m_if.data, $time);
      end else begin
        chk("out_word", m_if.data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b0;

    // 1: reset, then a single word with latency 1
    repeat (3) step();
    chk("rst_m_valid", {31'd0, m_if.valid}, 32'd0);
    chk("rst_m_data", m_if.data, 32'd0);
    chk("rst_s_ready", {31'd0, s_if.ready}, 32'd1);
    chk("rst_level", {30'd0, level}, 32'd0);
    arst_n = 1'b1;
    step();
    s_if.valid = 1'b1; s_if.data = 32'hA5A5A5A5; m_if.ready = 1'b1;
    exp_q.push_back(32'hA5A5A5A5);
    chk("t1_level0", {30'd0, level}, 32'd0);
    step();
    s_if.valid = 1'b0;
    chk("t1_m_valid", {31'd0, m_if.valid}, 32'd1);
    chk("t1_m_data", m_if.data, 32'hA5A5A5A5);
    chk("t1_level1", {30'd0, level}, 32'd1);
    step();
    chk("t1_level_end", {30'd0, level}, 32'd0);
    chk("t1_m_valid_end", {31'd0, m_if.valid}, 32'd0);

    // 2: streaming at full rate
    for (int i = 1; i <= 16; i++) begin
      s_if.valid = 1'b1; s_if.data = i;
      exp_q.push_back(i);
      chk("t2_s_ready", {31'd0, s_if.ready}, 32'd1);
      step();
      chk("t2_level", {30'd0, level}, 32'd1);
      chk("t2_m_data", m_if.data, i);
    end
    s_if.valid = 1'b0;
    step();
    chk("t2_level_end", {30'd0, level}, 32'd0);

    // 3: backpressure fills the skid entry, then drains in order
    m_if.ready = 1'b0;
    s_if.valid = 1'b1; s_if.data = 32'h10; exp_q.push_back(32'h10);
    step();
    s_if.data = 32'h11; exp_q.push_back(32'h11);
    step();
    chk("t3_level2", {30'd0, level}, 32'd2);
    chk("t3_s_ready0", {31'd0, s_if.ready}, 32'd0);
    s_if.data = 32'h12; exp_q.push_back(32'h12);
    step();
    chk("t3_level_held", {30'd0, level}, 32'd2);
    chk("t3_m_data_stable", m_if.data, 32'h10);
    m_if.ready = 1'b1;
    step();
    chk("t3_s_ready_back", {31'd0, s_if.ready}, 32'd1);
    chk("t3_level_one", {30'd0, level}, 32'd1);
    chk("t3_m_data_skid", m_if.data, 32'h11);
    step();
    s_if.valid = 1'b0;
    chk("t3_m_data_last", m_if.data, 32'h12);
    step();
    chk("t3_level_end", {30'd0, level}, 32'd0);

    // 4: simultaneous input and output while holding one word
    m_if.ready = 1'b0;
    s_if.valid = 1'b1; s_if.data = 32'h20; exp_q.push_back(32'h20);
    step();
    s_if.valid = 1'b0;
    chk("t4_level1", {30'd0, level}, 32'd1);
    step();
    s_if.valid = 1'b1; s_if.data = 32'h21; exp_q.push_back(32'h21); m_if.ready = 1'b1;
    step();
    s_if.valid = 1'b0;
    chk("t4_m_data", m_if.data, 32'h21);
    chk("t4_level", {30'd0, level}, 32'd1);
    step();
    chk("t4_level_end", {30'd0, level}, 32'd0);

    // 5: flush while full beats a simultaneous handshake on both sides
    m_if.ready = 1'b0;
    s_if.valid = 1'b1; s_if.data = 32'h30;
    step();
    s_if.data = 32'h31;
    step();
    chk("t5_level2", {30'd0, level}, 32'd2);
    rst = 1'b1; s_if.data = 32'h32; m_if.ready = 1'b1;
    step();
    rst = 1'b0; s_if.valid = 1'b0;
    chk("t5_m_valid", {31'd0, m_if.valid}, 32'd0);
    chk("t5_level", {30'd0, level}, 32'd0);
    chk("t5_s_ready", {31'd0, s_if.ready}, 32'd1);
    chk("t5_m_data_kept", m_if.data, 32'h30);
    step();
    chk("t5_m_valid_after", {31'd0, m_if.valid}, 32'd0);

    // 6: asynchronous reset between edges while full
    m_if.ready = 1'b0;
    s_if.valid = 1'b1; s_if.data = 32'h50;
    step();
    s_if.data = 32'h51;
    step();
    s_if.valid = 1'b0;
    chk("t6_level2", {30'd0, level}, 32'd2);
    #2 arst_n = 1'b0;
    #1;
    chk("t6_m_valid", {31'd0, m_if.valid}, 32'd0);
    chk("t6_m_data", m_if.data, 32'd0);
    chk("t6_level", {30'd0, level}, 32'd0);
    chk("t6_s_ready", {31'd0, s_if.ready}, 32'd1);
    step();
    arst_n = 1'b1;
    step();
    s_if.valid = 1'b1; s_if.data = 32'h40; m_if.ready = 1'b1; exp_q.push_back(32'h40);
    step();
    s_if.valid = 1'b0;
    chk("t6_new_valid", {31'd0, m_if.valid}, 32'd1);
    chk("t6_new_data", m_if.data, 32'h40);
    step();
    chk("t6_level_end", {30'd0, level}, 32'd0);

    step();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
